// File: rtl/aud_dsp.sv
// aud_dsp: playback sample generator feeding the I2S DAC serializer.
// Produces one 16-bit signed sample per LRC frame from the audio SRAM.
// Speed control: fast (sample skip), slow-constant (sample hold) and
// slow-linear (interpolation between the previous and current sample).
module aud_dsp #(
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_slow_0,
  input  logic              i_slow_1,
  input  logic [2:0]        i_speed,
  input  logic              i_daclrck,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [15:0]       i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_dac_data,
  output logic              o_en,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_CALC  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_stateNext;
  logic   w_en;

  // The address register is one bit wider than the SRAM address so that a
  // step past the top of memory still compares as beyond the end address.
  logic [ADDR_W:0]    r_addr;
  logic [2:0]         r_k;
  logic signed [15:0] r_prev;
  logic signed [15:0] r_cur;
  logic signed [15:0] r_dacData;
  logic               r_pausePend;
  logic               r_lrcD;

  logic               w_lrcRise;
  logic               w_beyond;
  logic               w_modeFast;
  logic               w_modeSlow1;
  logic               w_modeSlow0;
  logic               w_modeSlow;
  logic [3:0]         w_n;
  logic [2:0]         w_kEff;
  logic               w_groupEnd;
  logic [3:0]         w_kPlus1;
  logic signed [16:0] w_diff;
  logic signed [19:0] w_prod;
  logic signed [19:0] w_quot;
  logic signed [15:0] w_interp;
  logic signed [15:0] w_calcOut;
  logic [ADDR_W:0]    w_addrStep;
  logic [ADDR_W:0]    w_addrSum;
  logic [2:0]         w_kNext;
  logic signed [15:0] w_prevNext;
  logic               w_unused;

  assign w_lrcRise = ~r_lrcD & i_daclrck;
  assign w_beyond  = r_addr > {1'b0, i_end_addr};

  // Mode priority: fast, then linear slow, then constant slow, then normal.
  assign w_modeFast  = i_fast;
  assign w_modeSlow1 = ~i_fast & i_slow_1;
  assign w_modeSlow0 = ~i_fast & ~i_slow_1 & i_slow_0;
  assign w_modeSlow  = w_modeSlow1 | w_modeSlow0;

  // N = speed + 1, so N-1 is simply i_speed. A k left over from a larger N
  // is clamped to the last frame of the group.
  assign w_n        = {1'b0, i_speed} + 4'd1;
  assign w_kEff     = (r_k > i_speed) ? i_speed : r_k;
  assign w_groupEnd = (w_kEff == i_speed);
  assign w_kPlus1   = {1'b0, w_kEff} + 4'd1;

  // Linear interpolation: prev + (cur - prev) * (k+1) / N, signed division
  // truncating toward zero. The quotient always lies between 0 and the
  // difference, so its low 16 bits added to prev give the exact result.
  assign w_diff   = {r_cur[15], r_cur} - {r_prev[15], r_prev};
  assign w_prod   = {{3{w_diff[16]}}, w_diff} * $signed({16'd0, w_kPlus1});
  assign w_quot   = w_prod / $signed({16'd0, w_n});
  assign w_interp = r_prev + w_quot[15:0];
  assign w_unused = ^w_quot[19:16];

  assign w_calcOut = w_modeSlow1 ? w_interp : r_cur;

  // Per-frame address step, plus next k / prev for the slow group counter.
  always_comb begin
    w_addrStep = '0;
    w_kNext    = 3'd0;
    w_prevNext = r_cur;
    if (w_modeFast) begin
      w_addrStep = (ADDR_W+1)'(w_n);
    end else if (w_modeSlow) begin
      if (w_groupEnd) begin
        w_addrStep = (ADDR_W+1)'(1);
      end else begin
        w_kNext    = w_kEff + 3'd1;
        w_prevNext = r_prev;
      end
    end else begin
      w_addrStep = (ADDR_W+1)'(1);
    end
  end

  assign w_addrSum = r_addr + w_addrStep;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and serializer enable; stop overrides every other request.
  always_comb begin
    w_stateNext = r_state;
    w_en        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        w_en = 1'b1;
        if (w_lrcRise) begin
          if (w_beyond) begin
            w_stateNext = S_IDLE;
          end else if (r_pausePend) begin
            w_stateNext = S_PAUSE;
          end else begin
            w_stateNext = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_en        = 1'b1;
        w_stateNext = S_CALC;
      end
      S_CALC: begin
        w_en        = 1'b1;
        w_stateNext = S_WAIT;
      end
      S_PAUSE: begin
        if (i_start) begin
          w_stateNext = S_WAIT;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
    if (i_stop) begin
      w_stateNext = S_IDLE;
    end
  end

  // Datapath registers: address, slow-group index, samples and pause request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_k         <= 3'd0;
      r_prev      <= '0;
      r_cur       <= '0;
      r_dacData   <= '0;
      r_pausePend <= 1'b0;
      r_lrcD      <= 1'b0;
    end else begin
      r_lrcD <= i_daclrck;
      if (i_stop) begin
        r_addr      <= '0;
        r_k         <= 3'd0;
        r_prev      <= '0;
        r_dacData   <= '0;
        r_pausePend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_addr      <= '0;
              r_k         <= 3'd0;
              r_prev      <= '0;
              r_pausePend <= 1'b0;
            end
          end
          S_WAIT: begin
            if (w_lrcRise && w_beyond) begin
              r_dacData <= '0;
            end
            if (w_lrcRise && !w_beyond && r_pausePend) begin
              r_pausePend <= 1'b0;
            end else if (i_pause) begin
              r_pausePend <= 1'b1;
            end
          end
          S_FETCH: begin
            r_cur <= i_sram_data;
            if (i_pause) begin
              r_pausePend <= 1'b1;
            end
          end
          S_CALC: begin
            r_dacData <= w_calcOut;
            r_addr    <= w_addrSum;
            r_k       <= w_kNext;
            r_prev    <= w_prevNext;
            if (i_pause) begin
              r_pausePend <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_sram_addr = r_addr[ADDR_W-1:0];
  assign o_dac_data  = r_dacData;
  assign o_en        = w_en;
  assign o_state     = r_state;

endmodule
